pe_vec_mac: RTL

//  Multi-lane processing element for the softmax datapath: LANES independent signed lanes, each doing ADD, MUL or

---
 rtl/pe_vec_mac_pkg.sv | 48 ++++
 rtl/pe_vec_mac_if.sv | 37 +++
 rtl/pe_vec_mac_lane.sv | 62 ++++++
 rtl/pe_vec_mac.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pe_vec_mac_pkg.sv
// +---------------------------------------------------------------------------+
// | pe_pkg : shared modes, FSM states and saturating-add helpers (rev 1.0)    |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package pe_pkg;

   localparam int LANES_DEF  = 4;
   localparam int IFM_W_DEF  = 8;
   localparam int WGT_W_DEF  = 8;
   localparam int DATA_W_DEF = 16;
   localparam int LEN_W_DEF  = 8;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_MUL = 2'b01;
   localparam logic [1:0] MODE_MAC = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Lane arithmetic runs at this width so no intermediate can overflow before clipping.
   typedef logic signed [63:0] wide_t;

   function automatic wide_t sat_clip(input wide_t v, input int unsigned w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
      return sat_clip(a + b, w);
   endfunction

   function automatic logic is_mult(input logic [1:0] m);
      return (m == MODE_MUL) || (m == MODE_MAC);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pe_vec_mac_if.sv
// +---------------------------------------------------------------------------+
// | pe_vec_mac_if : control, input-beat and result handshake bundle (rev 1.0) |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface pe_vec_mac_if #(
   parameter int LANES      = 4,
   parameter int IFM_WIDTH  = 8,
   parameter int WGT_WIDTH  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
);
   logic                        clear;
   logic [1:0]                  mode;
   logic [LEN_WIDTH-1:0]        acc_len;
   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*IFM_WIDTH-1:0]  in1;
   logic [LANES*WGT_WIDTH-1:0]  in2;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES*DATA_WIDTH-1:0] psum_out;
   logic                        busy;

   modport master (
      output clear, mode, acc_len, in_valid, in1, in2, out_ready,
      input  in_ready, out_valid, psum_out, busy
   );

   modport slave (
      input  clear, mode, acc_len, in_valid, in1, in2, out_ready,
      output in_ready, out_valid, psum_out, busy
   );
endinterface

`default_nettype wire

// File: rtl/pe_vec_mac_lane.sv
// +---------------------------------------------------------------------------+
// | pe_lane : one lane's term, accumulator and optional saturation (rev 1.0)  |
// | Build option: PE_SAT_EN selects saturating adds instead of wrap-around.   |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pe_lane
   import pe_pkg::*;
#(
   parameter int IFM_WIDTH  = IFM_W_DEF,
   parameter int WGT_WIDTH  = WGT_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   input  wire logic                         clear_i,
   input  wire logic                         first_i,
   input  wire logic                         accum_i,
   input  wire logic [1:0]                   mode_i,
   input  wire logic signed [IFM_WIDTH-1:0]  in1_i,
   input  wire logic signed [WGT_WIDTH-1:0]  in2_i,
   output logic      signed [DATA_WIDTH-1:0] term_o,
   output logic      signed [DATA_WIDTH-1:0] sum_o
);

   logic signed [DATA_WIDTH-1:0] acc_q;
   logic signed [DATA_WIDTH-1:0] acc_d;
   wide_t                        w_a;
   wide_t                        w_b;
   wide_t                        w_raw_term;
   wide_t                        w_raw_sum;

   always_comb begin
      w_a        = wide_t'(in1_i);
      w_b        = wide_t'(in2_i);
      w_raw_term = is_mult(mode_i) ? (w_a * w_b) : (w_a + w_b);
`ifdef PE_SAT_EN
      term_o     = DATA_WIDTH'(sat_clip(w_raw_term, DATA_WIDTH));
      w_raw_sum  = sat_add(wide_t'(acc_q), wide_t'(term_o), DATA_WIDTH);
`else
      term_o     = DATA_WIDTH'(w_raw_term);
      w_raw_sum  = wide_t'(acc_q) + wide_t'(term_o);
`endif
      sum_o      = DATA_WIDTH'(w_raw_sum);
   end

   always_comb begin
      acc_d = acc_q;
      if (clear_i)      acc_d = '0;
      else if (first_i) acc_d = term_o;
      else if (accum_i) acc_d = sum_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

endmodule

`default_nettype wire

// File: rtl/pe_vec_mac.sv
// +---------------------------------------------------------------------------+
// | pe_vec_mac : multi-lane ADD/MUL/MAC element with valid/ready (rev 1.0)    |
// | Build option: PE_SAT_EN enables per-lane saturation inside pe_lane.       |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pe_vec_mac
   import pe_pkg::*;
#(
   parameter int LANES      = LANES_DEF,
   parameter int IFM_WIDTH  = IFM_W_DEF,
   parameter int WGT_WIDTH  = WGT_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int LEN_WIDTH  = LEN_W_DEF
) (
   input wire logic    clk,
   input wire logic    rst_n,
   pe_vec_mac_if.slave bus
);

   state_e                      state_q;
   logic [1:0]                  mode_q;
   logic [LEN_WIDTH-1:0]        len_q;
   logic [LEN_WIDTH-1:0]        cnt_q;
   logic                        out_valid_q;
   logic                        busy_q;
   logic [LANES*DATA_WIDTH-1:0] psum_q;

   logic [LANES*DATA_WIDTH-1:0] w_term_vec;
   logic [LANES*DATA_WIDTH-1:0] w_sum_vec;
   logic                        w_in_ready;
   logic                        w_beat;
   logic                        w_first;
   logic                        w_accum;
   logic                        w_first_done;
   logic                        w_last;
   logic [LEN_WIDTH-1:0]        w_len_eff;
   logic [1:0]                  w_mode_sel;

   // A held result frees the slot in the same cycle it is consumed.
   assign w_in_ready   = (state_q != ST_HOLD) || bus.out_ready;
   assign w_beat       = bus.in_valid && w_in_ready && !bus.clear;
   assign w_first      = w_beat && (state_q != ST_ACCUM);
   assign w_accum      = w_beat && (state_q == ST_ACCUM);
   assign w_len_eff    = (bus.acc_len == '0) ? LEN_WIDTH'(1) : bus.acc_len;
   assign w_first_done = (bus.mode != MODE_MAC) || (w_len_eff == LEN_WIDTH'(1));
   assign w_last       = (cnt_q == (len_q - LEN_WIDTH'(1)));
   assign w_mode_sel   = w_first ? bus.mode : mode_q;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.psum_out  = psum_q;
   assign bus.busy      = busy_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      pe_lane #(
         .IFM_WIDTH  (IFM_WIDTH),
         .WGT_WIDTH  (WGT_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear_i (bus.clear),
         .first_i (w_first),
         .accum_i (w_accum),
         .mode_i  (w_mode_sel),
         .in1_i   (bus.in1[g*IFM_WIDTH +: IFM_WIDTH]),
         .in2_i   (bus.in2[g*WGT_WIDTH +: WGT_WIDTH]),
         .term_o  (w_term_vec[g*DATA_WIDTH +: DATA_WIDTH]),
         .sum_o   (w_sum_vec[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_ADD;
         len_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         psum_q      <= '0;
      end else if (bus.clear) begin
         // psum_q deliberately keeps its last value across an abort.
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (w_first) begin
         mode_q <= bus.mode;
         len_q  <= w_len_eff;
         busy_q <= 1'b1;
         if (w_first_done) begin
            state_q     <= ST_HOLD;
            psum_q      <= w_term_vec;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
         end else begin
            state_q     <= ST_ACCUM;
            out_valid_q <= 1'b0;
            cnt_q       <= LEN_WIDTH'(1);
         end
      end else if (w_accum) begin
         if (w_last) begin
            state_q     <= ST_HOLD;
            psum_q      <= w_sum_vec;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
         end else begin
            cnt_q <= cnt_q + LEN_WIDTH'(1);
         end
      end else if ((state_q == ST_HOLD) && bus.out_ready) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end
   end

endmodule

`default_nettype wire
